a8_bus_capture: RTL and testbench
=================================

A8_BUS_CAPTURE -- requirements
Module: a8_bus_capture

Interface
REQ-001 SHALL have parameter SAMPLE_DLY, default 48: clk200 cycles from detected phi2 rise to bus sample (240 ns).
REQ-002 SHALL have parameter BASE_PAGE, default 8'hD6: address high byte decoded as the pixl register page.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, power of two.
REQ-004 SHALL have port clk200, input, 1: sole clock, 200 MHz.
REQ-005 SHALL have port a8_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port a8_clk, input, 1: Atari phi2, asynchronous to clk200.
REQ-007 SHALL have port a8_addr, input, 16: Atari address bus, asynchronous.
REQ-008 SHALL have port a8_data, input, 8: Atari data bus, asynchronous.
REQ-009 SHALL have port a8_rw_n, input, 1: Atari read/write, low = write.
REQ-010 SHALL have port ev_valid, output, 1: event available at the queue head.
REQ-011 SHALL have port ev_ready, input, 1: consumer accepts the head event.
REQ-012 SHALL have port ev_addr, output, 8: register offset, a8_addr[7:0].
REQ-013 SHALL have port ev_data, output, 8: written data byte.
REQ-014 SHALL have port ovf, output, 1: sticky flag, event dropped because the queue was full.
REQ-015 SHALL have port short_err, output, 1: sticky flag, phi2 fell before the sample point.
REQ-016 SHALL have port clr_err, input, 1: one-cycle pulse that clears ovf and short_err.

Function
REQ-017 SHALL pass a8_clk through two flops, plus a third flop for edge detection; rise and fall are single-cycle pulses in the clk200 domain.
REQ-018 SHALL implement FSM states ARM, IDLE, COUNT and HOLD; reset state is ARM.
REQ-019 ARM SHALL go to IDLE when synced phi2 is low, so no capture starts mid-cycle after reset.
REQ-020 IDLE SHALL go to COUNT on rise and load the counter with 0; call this cycle E.
REQ-021 COUNT SHALL increment each cycle.
REQ-022 At cycle E+SAMPLE_DLY, COUNT SHALL capture a8_addr, a8_data and a8_rw_n, then go to HOLD.
REQ-023 If fall occurs in COUNT before the sample, the FSM SHALL set short_err, push nothing, and go to IDLE.
REQ-024 HOLD SHALL go to IDLE on fall.
REQ-025 A capture with a8_addr[15:8]==BASE_PAGE and a8_rw_n==0 SHALL push {addr[7:0], data}.
REQ-026 All other captures, including reads and other pages, SHALL be discarded.
REQ-027 When the queue was empty, ev_valid SHALL rise at cycle E+SAMPLE_DLY+1.
REQ-028 ev_addr and ev_data SHALL show the head entry and SHALL remain stable while ev_valid=1 and ev_ready=0.
REQ-029 A pop SHALL occur exactly when ev_valid and ev_ready are both 1.
REQ-030 A push to a full queue SHALL be dropped and SHALL set ovf, unless a pop happens in the same cycle; in that case the push is accepted and ovf is not set.
REQ-031 A push and pop on an empty queue SHALL be legal; the pushed entry appears the next cycle.
REQ-032 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 Full and empty SHALL be distinguished by an extra pointer bit.
REQ-034 If clr_err and a new error occur in the same cycle, the flag SHALL remain set.

Reset
REQ-035 a8_rst_n low SHALL asynchronously force: FSM=ARM, counter=0, sync flops=0, queue empty, ev_valid=0, ev_addr=0, ev_data=0, ovf=0, short_err=0.
REQ-036 Reset during COUNT or HOLD SHALL abort the cycle with no event and no error flag.
REQ-037 Reset release SHALL be synchronised to clk200 (deassert via two flops).

Structure
REQ-038 Package pixl_pkg SHALL hold BASE_PAGE, the FSM state encoding and the event width (16).
REQ-039 The queue SHALL be sub-module a8_evt_fifo (synchronous FIFO with valid/ready and a full flag); the synchroniser and FSM stay in a8_bus_capture.

Verification
REQ-040 Scenario: phi2 at 288 ns half-period, addr=0xD600, data=0x90, rw_n=0 -> one event with ev_addr=0x00 and ev_data=0x90; ev_valid at E+49.
REQ-041 Scenario: addr=0x0600, data=0x70, rw_n=1, then addr=0xD6FF with rw_n=1 -> no events, no flags.
REQ-042 Scenario: five writes to 0xD601..0xD605 with ev_ready=0 -> 4 events held (0x01..0x04), ovf=1, 0x05 lost; clr_err -> ovf=0.
REQ-043 Scenario: queue full, and ev_ready=1 in the same cycle as the fifth write's push -> ovf stays 0 and 0x05 is eventually delivered.
REQ-044 Scenario: phi2 high pulse of 100 ns with SAMPLE_DLY=48 -> short_err=1 and no event.
REQ-045 Scenario: assert a8_rst_n during COUNT, release while phi2 is high -> no event until phi2 has been seen low, then the next write is captured normally.

Source files
------------

// File: rtl/pixl_pkg.sv
// Shared definitions for the Atari 8-bit bus capture block: register page,
// capture FSM encoding and the event payload written into the queue.
package pixl_pkg;

    localparam logic [7:0]  BASE_PAGE = 8'hD6;
    localparam int unsigned EV_W      = 16;
    localparam int unsigned ARM_FILL  = 2;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_COUNT = 2'd2,
        ST_HOLD  = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    function automatic logic is_page_write(input logic [15:0] addr, input logic rw_n,
                                           input logic [7:0] page);
        return (addr[15:8] == page) && !rw_n;
    endfunction

endpackage

// File: rtl/a8_evt_fifo.sv
// Synchronous event queue with valid/ready pop side; head entry is registered
// so ev_addr/ev_data come straight from flops.
module a8_evt_fifo
    import pixl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  ev_t  push_data,
    input  logic pop_ready,
    output logic pop_valid,
    output ev_t  pop_data,
    output logic full_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          valid_q, valid_d;
    ev_t           head_q, head_d;
    ev_t           mem_q [DEPTH];
    logic          pop_c;
    logic          push_c;

    // A push into a full queue is still accepted when the head leaves in the same cycle.
    always_comb begin
        full_c  = (wr_q ^ rd_q) == PW'(DEPTH);
        pop_c   = valid_q & pop_ready;
        push_c  = push_valid & (~full_c | pop_c);
        wr_d    = wr_q + PW'(push_c);
        rd_d    = rd_q + PW'(pop_c);
        valid_d = (wr_d != rd_d);
        head_d  = head_q;
        if (wr_q == rd_d) begin
            if (push_c) begin
                head_d = push_data;
            end
        end else begin
            head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_valid = valid_q;
    assign pop_data  = head_q;

endmodule

// File: rtl/a8_bus_capture.sv
// Samples Atari phi2 bus cycles in the clk200 domain and queues writes to the
// pixl register page as {offset, data} events.
module a8_bus_capture
    import pixl_pkg::*;
#(
    parameter int unsigned SAMPLE_DLY = 48,
    parameter logic [7:0]  BASE_PAGE  = pixl_pkg::BASE_PAGE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk200,
    input  logic        a8_rst_n,
    input  logic        a8_clk,
    input  logic [15:0] a8_addr,
    input  logic [7:0]  a8_data,
    input  logic        a8_rw_n,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_addr,
    output logic [7:0]  ev_data,
    output logic        ovf,
    output logic        short_err,
    input  logic        clr_err
);

    localparam int unsigned CNT_RAW = $clog2(SAMPLE_DLY + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 2) ? CNT_RAW : 2;
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_DLY - 1);

    logic             rst_meta_q, rst_sync_q;
    logic             rst_n;
    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       phi_q, phi_d;
    ev_t              cap_q, cap_d;
    logic             push_q, push_d;
    logic             ovf_q, ovf_d;
    logic             short_q, short_d;
    logic             rise_c, fall_c;
    logic             short_set_c;
    logic             drop_c;
    logic             full_c;
    ev_t              head_c;

    // Reset asserts immediately, releases two clk200 edges later.
    always_ff @(posedge clk200 or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n = rst_sync_q;

    // ARM waits for the synchroniser to fill before trusting phi_q[1].
    always_comb begin
        phi_d       = {phi_q[1:0], a8_clk};
        rise_c      = phi_q[1] & ~phi_q[2];
        fall_c      = ~phi_q[1] & phi_q[2];
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        push_d      = 1'b0;
        short_set_c = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (cnt_q < CNT_W'(ARM_FILL)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!phi_q[1]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise_c) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
            end
            ST_COUNT: begin
                if (fall_c) begin
                    short_set_c = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q == SAMPLE_LAST) begin
                    state_d    = ST_HOLD;
                    cap_d.addr = a8_addr[7:0];
                    cap_d.data = a8_data;
                    push_d     = is_page_write(a8_addr, a8_rw_n, BASE_PAGE);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_ARM;
        endcase

        drop_c  = push_q & full_c & ~(ev_valid & ev_ready);
        ovf_d   = (ovf_q & ~clr_err) | drop_c;
        short_d = (short_q & ~clr_err) | short_set_c;
    end

    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            phi_q   <= '0;
            cap_q   <= '0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            cap_q   <= cap_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
        end
    end

    a8_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk200),
        .rst_n      (rst_n),
        .push_valid (push_q),
        .push_data  (cap_q),
        .pop_ready  (ev_ready),
        .pop_valid  (ev_valid),
        .pop_data   (head_c),
        .full_c     (full_c)
    );

    assign ev_addr   = head_c.addr;
    assign ev_data   = head_c.data;
    assign ovf       = ovf_q;
    assign short_err = short_q;

endmodule

// File: tb/tb_a8_bus_capture.sv
// Bench for a8_bus_capture: phi2 edges placed on the clk200 grid so the
// reference queue knows the exact edge at which each event or error lands.
module tb_a8_bus_capture;

    localparam int D     = 48;
    localparam int DEPTH = 4;

    logic        clk200   = 1'b0;
    logic        a8_rst_n = 1'b0;
    logic        a8_clk   = 1'b0;
    logic [15:0] a8_addr  = 16'h0;
    logic [7:0]  a8_data  = 8'h0;
    logic        a8_rw_n  = 1'b1;
    logic        ev_ready = 1'b0;
    logic        clr_err  = 1'b0;
    logic        ev_valid;
    logic [7:0]  ev_addr;
    logic [7:0]  ev_data;
    logic        ovf;
    logic        short_err;

    typedef struct {
        int          at;
        bit          is_short;
        logic [15:0] ev;
    } sched_t;

    sched_t      sched[$];
    int          si = 0;
    logic [15:0] mq[$];
    logic [15:0] popped[$];
    bit          m_ovf = 0;
    bit          m_short = 0;
    int          cyc = 0;
    bit          rand_mode = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    a8_bus_capture #(
        .SAMPLE_DLY (48),
        .BASE_PAGE  (8'hD6),
        .FIFO_DEPTH (4)
    ) dut (
        .clk200    (clk200),
        .a8_rst_n  (a8_rst_n),
        .a8_clk    (a8_clk),
        .a8_addr   (a8_addr),
        .a8_data   (a8_data),
        .a8_rw_n   (a8_rw_n),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_addr   (ev_addr),
        .ev_data   (ev_data),
        .ovf       (ovf),
        .short_err (short_err),
        .clr_err   (clr_err)
    );

    always #5 clk200 = ~clk200;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference queue: applies the pop, scheduled push/short and clear of one clk200 edge.
    task automatic model_edge();
        bit          pop;
        bit          has_push;
        bit          new_ovf;
        bit          new_short;
        logic [15:0] push_ev;
        if (!a8_rst_n) begin
            mq.delete();
            m_ovf   = 0;
            m_short = 0;
            si      = sched.size();
            return;
        end
        pop       = (mq.size() > 0) && ev_ready;
        has_push  = 0;
        new_ovf   = 0;
        new_short = 0;
        push_ev   = 16'h0;
        while (si < sched.size() && sched[si].at <= cyc) begin
            if (sched[si].is_short) new_short = 1;
            else begin
                has_push = 1;
                push_ev  = sched[si].ev;
            end
            si++;
        end
        if (pop) begin
            popped.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (has_push) begin
            if (mq.size() < DEPTH) mq.push_back(push_ev);
            else new_ovf = 1;
        end
        if (clr_err) begin
            m_ovf   = 0;
            m_short = 0;
        end
        if (new_ovf) m_ovf = 1;
        if (new_short) m_short = 1;
    endtask

    task automatic compare();
        if (!a8_rst_n) begin
            chk("rst_ev_valid", 16'(ev_valid), 16'h0);
            chk("rst_ev_addr", 16'(ev_addr), 16'h0);
            chk("rst_ev_data", 16'(ev_data), 16'h0);
            chk("rst_ovf", 16'(ovf), 16'h0);
            chk("rst_short_err", 16'(short_err), 16'h0);
        end else begin
            chk("ev_valid", 16'(ev_valid), 16'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("ev_addr", 16'(ev_addr), 16'(mq[0][15:8]));
                chk("ev_data", 16'(ev_data), 16'(mq[0][7:0]));
            end
            chk("ovf", 16'(ovf), 16'(m_ovf));
            chk("short_err", 16'(short_err), 16'(m_short));
        end
    endtask

    // One clk200 cycle: model at the rising edge, compare and re-drive at the falling edge.
    task automatic step();
        @(posedge clk200);
        cyc++;
        model_edge();
        @(negedge clk200);
        compare();
        clr_err = 1'b0;
        if (rand_mode) begin
            ev_ready = 1'($urandom_range(0, 1));
            clr_err  = 1'($urandom_range(0, 19) == 0);
        end
    endtask

    // phi2 high for h clk200 edges then low for l; rise reaches the FSM two edges later.
    task automatic phase(input logic [15:0] a, input logic [7:0] d, input logic rw,
                         input int h, input int l, input int rdy_off, input bit tchk);
        int k;
        a8_addr = a;
        a8_data = d;
        a8_rw_n = rw;
        a8_clk  = 1'b1;
        k = cyc + 1;
        if (h <= D) sched.push_back('{k + h + 2, 1'b1, 16'h0});
        else if (a[15:8] == 8'hD6 && !rw) sched.push_back('{k + D + 3, 1'b0, {a[7:0], d}});
        for (int i = 0; i < h; i++) begin
            step();
            if (rdy_off >= 0 && cyc == k + rdy_off) ev_ready = 1'b1;
            if (tchk && cyc == k + D + 2) chk("valid_at_E48", 16'(ev_valid), 16'h0);
            if (tchk && cyc == k + D + 3) begin
                chk("valid_at_E49", 16'(ev_valid), 16'h1);
                chk("first_ev_addr", 16'(ev_addr), 16'h00);
                chk("first_ev_data", 16'(ev_data), 16'h90);
            end
        end
        a8_clk = 1'b0;
        repeat (l) step();
    endtask

    initial begin
        logic [15:0] exp4 [4];
        logic [15:0] exp5 [5];
        logic [15:0] ra;
        exp4 = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
        exp5 = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555};

        // Reset and arm
        repeat (5) step();
        a8_rst_n = 1'b1;
        repeat (12) step();
        chk("post_reset_valid", 16'(ev_valid), 16'h0);

        // Single write to D600
        phase(16'hD600, 8'h90, 1'b0, 58, 58, -1, 1'b1);
        ev_ready = 1'b1;
        popped.delete();
        repeat (4) step();
        chk("s1_popped_cnt", 16'(popped.size()), 16'h1);
        chk("s1_popped", popped[0], 16'h0090);
        ev_ready = 1'b0;

        // Reads and other pages are ignored
        phase(16'h0600, 8'h70, 1'b1, 58, 10, -1, 1'b0);
        phase(16'hD6FF, 8'h55, 1'b1, 58, 10, -1, 1'b0);
        chk("s2_valid", 16'(ev_valid), 16'h0);
        chk("s2_ovf", 16'(ovf), 16'h0);
        chk("s2_short", 16'(short_err), 16'h0);

        // Overflow with consumer stalled, then clear
        popped.delete();
        for (int i = 1; i <= 5; i++)
            phase(16'hD600 + 16'(i), 8'(8'h11 * i), 1'b0, 58, 10, -1, 1'b0);
        chk("s3_ovf_set", 16'(ovf), 16'h1);
        chk("s3_head_held", 16'(ev_addr), 16'h01);
        clr_err = 1'b1;
        step();
        chk("s3_ovf_clr", 16'(ovf), 16'h0);
        ev_ready = 1'b1;
        repeat (8) step();
        ev_ready = 1'b0;
        chk("s3_popped_cnt", 16'(popped.size()), 16'h4);
        for (int i = 0; i < 4; i++) chk("s3_popped", popped[i], exp4[i]);

        // Full queue with a pop in the push cycle
        popped.delete();
        for (int i = 1; i <= 4; i++)
            phase(16'hD600 + 16'(i), 8'(8'h11 * i), 1'b0, 58, 10, -1, 1'b0);
        phase(16'hD605, 8'h55, 1'b0, 58, 10, D + 2, 1'b0);
        repeat (8) step();
        ev_ready = 1'b0;
        chk("s4_ovf", 16'(ovf), 16'h0);
        chk("s4_popped_cnt", 16'(popped.size()), 16'h5);
        for (int i = 0; i < 5; i++) chk("s4_popped", popped[i], exp5[i]);

        // Short phi2 high pulse
        phase(16'hD620, 8'hAB, 1'b0, 20, 20, -1, 1'b0);
        chk("s5_short", 16'(short_err), 16'h1);
        chk("s5_valid", 16'(ev_valid), 16'h0);
        clr_err = 1'b1;
        step();
        chk("s5_short_clr", 16'(short_err), 16'h0);

        // Reset mid-COUNT, released while phi2 is still high
        popped.delete();
        ev_ready = 1'b1;
        a8_addr = 16'hD611;
        a8_data = 8'h33;
        a8_rw_n = 1'b0;
        a8_clk  = 1'b1;
        repeat (20) step();
        a8_rst_n = 1'b0;
        repeat (5) step();
        a8_rst_n = 1'b1;
        repeat (40) step();
        a8_clk = 1'b0;
        repeat (20) step();
        chk("s6_no_event", 16'(popped.size()), 16'h0);
        phase(16'hD612, 8'h44, 1'b0, 58, 20, -1, 1'b0);
        chk("s6_popped_cnt", 16'(popped.size()), 16'h1);
        chk("s6_popped", popped[0], 16'h1244);
        chk("s6_short", 16'(short_err), 16'h0);

        // Randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) ra = {8'hD6, 8'($urandom)};
            else ra = 16'($urandom);
            phase(ra, 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  int'($urandom_range(10, 70)), int'($urandom_range(8, 30)), -1, 1'b0);
        end
        rand_mode = 0;
        clr_err   = 1'b0;
        ev_ready  = 1'b1;
        repeat (20) step();
        chk("final_drain", 16'(ev_valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
